// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer.
//   - state_t   : FSM encodings (IDLE, SHIFT, DONE)
//   - DIR_LEFT / DIR_RIGHT : shift direction encodings
//   - DEF_WIDTH / DEF_AMT_W : default datapath and amount widths
// Optional feature macro: SHIFT_SEQUENCER_ROTATE_EN (used by the other files).
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_AMT_W = 4;

endpackage

// File: rtl/shift_step_unit.sv
// One combinational shift step: moves data by 2 or 1 bit positions.
// Ports:
//   data    in  WIDTH  value to step
//   dir     in  1      DIR_LEFT / DIR_RIGHT
//   two     in  1      1 = step by 2, 0 = step by 1
//   rot     in  1      1 = rotate instead of zero-fill (only with
//                      SHIFT_SEQUENCER_ROTATE_EN defined)
//   stepped out WIDTH  stepped value
// Without SHIFT_SEQUENCER_ROTATE_EN all vacated bits are filled with 0.
module shift_step_unit
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic             dir,
  input  logic             two,
`ifdef SHIFT_SEQUENCER_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] stepped
);

  logic rot_en;

`ifdef SHIFT_SEQUENCER_ROTATE_EN
  assign rot_en = rot;
`else
  assign rot_en = 1'b0;
`endif

  // Bits that re-enter at the vacated end: the bits leaving the other end
  // when rotating, zero otherwise.
  logic [1:0] fill_left2;
  logic [1:0] fill_right2;
  logic       fill_left1;
  logic       fill_right1;

  assign fill_left2  = rot_en ? data[WIDTH-1:WIDTH-2] : 2'b00;
  assign fill_right2 = rot_en ? data[1:0]             : 2'b00;
  assign fill_left1  = rot_en & data[WIDTH-1];
  assign fill_right1 = rot_en & data[0];

  always_comb begin
    stepped = data;
    if (dir == DIR_LEFT) begin
      if (two) stepped = {data[WIDTH-3:0], fill_left2};
      else     stepped = {data[WIDTH-2:0], fill_left1};
    end else begin
      if (two) stepped = {fill_right2, data[WIDTH-1:2]};
      else     stepped = {fill_right1, data[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller. Performs a 0..2^AMT_W-1 bit logical shift
// by iterating a 2-bit/1-bit step unit, one step per clock.
//
// Handshake: a transfer happens on a rising clk edge where both valid and
// ready are high. The requester holds req_valid and all req_* fields stable
// until accepted; the block holds resp_valid and resp_data stable until
// resp_ready is sampled high.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  high only in IDLE
//   req_data   in   WIDTH operand
//   req_amt    in   AMT_W shift distance
//   req_dir    in   0 = left, 1 = logical right
//   req_rot    in   rotate instead of shift (SHIFT_SEQUENCER_ROTATE_EN only)
//   resp_valid out  high only in DONE
//   resp_ready in   consumer accepts result
//   resp_data  out  WIDTH registered result
//   busy       out  high whenever not IDLE
//   state      out  current FSM state (debug visibility)
// Optional feature macro: SHIFT_SEQUENCER_ROTATE_EN
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [AMT_W-1:0] req_amt,
  input  logic             req_dir,
`ifdef SHIFT_SEQUENCER_ROTATE_EN
  input  logic             req_rot,
`endif
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             busy,
  output logic [1:0]       state
);

  state_t           state_q;
  state_t           state_next;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] rem_q;
  logic             dir_q;
  logic [WIDTH-1:0] stepped;
  logic             step_two;
  logic             accept;

`ifdef SHIFT_SEQUENCER_ROTATE_EN
  logic rot_q;
`endif

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign state      = state_q;
  assign resp_data  = data_q;
  assign accept     = req_valid & req_ready;
  assign step_two   = (rem_q >= AMT_W'(2));

  shift_step_unit #(
    .WIDTH (WIDTH)
  ) u_step (
    .data    (data_q),
    .dir     (dir_q),
    .two     (step_two),
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    .rot     (rot_q),
`endif
    .stepped (stepped)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) state_next = (req_amt != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        // rem of 1 or 2 is consumed entirely by this step.
        if (rem_q <= AMT_W'(2)) state_next = DONE;
      end
      DONE: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on accept, step while in SHIFT, otherwise hold. resp_data
  // therefore keeps its value through DONE and after the response handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      rem_q  <= '0;
      dir_q  <= DIR_LEFT;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
      rot_q  <= 1'b0;
`endif
    end else if (accept) begin
      data_q <= req_data;
      rem_q  <= req_amt;
      dir_q  <= req_dir;
`ifdef SHIFT_SEQUENCER_ROTATE_EN
      rot_q  <= req_rot;
`endif
    end else if (state_q == SHIFT) begin
      data_q <= stepped;
      rem_q  <= step_two ? (rem_q - AMT_W'(2)) : '0;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with hand-computed expected values.
// Optional feature macro: SHIFT_SEQUENCER_ROTATE_EN (adds rotate vectors).
module tb_shift_sequencer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_data;
  logic [3:0]  req_amt;
  logic        req_dir;
  logic        req_rot;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        busy;
  logic [1:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  shift_sequencer #(
    .WIDTH (16),
    .AMT_W (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_amt    (req_amt),
    .req_dir    (req_dir),
`ifdef SHIFT_SEQUENCER_ROTATE_EN
    .req_rot    (req_rot),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy),
    .state      (state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return just after the edge that accepts it.
  task automatic start_req(input logic [15:0] d, input logic [3:0] a,
                           input logic dr, input logic rt);
    int guard;
    req_data  = d;
    req_amt   = a;
    req_dir   = dr;
    req_rot   = rt;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      step();
      guard++;
    end
    check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  // Count edges from the accept edge to the first resp_valid cycle.
  task automatic wait_resp(input string tag, input int exp_lat,
                           input logic [15:0] exp_data, input logic exp_shift);
    int   lat;
    logic saw_shift;
    logic busy_ok;
    lat       = 1;
    saw_shift = (state == 2'd1);
    busy_ok   = busy;
    while (!resp_valid && lat < 40) begin
      step();
      lat++;
      if (state == 2'd1) saw_shift = 1'b1;
      if (!busy) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_data"}, {16'd0, resp_data}, {16'd0, exp_data});
    check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_saw_shift"}, {31'd0, saw_shift}, {31'd0, exp_shift});
  endtask

  task automatic finish_resp(input string tag, input logic [15:0] exp_data);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check({tag, "_idle_state"}, {30'd0, state}, 32'd0);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_resp_valid_low"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_data_kept"}, {16'd0, resp_data}, {16'd0, exp_data});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, {30'd0, state}, 32'd0);
    check({tag, "_resp_data"}, {16'd0, resp_data}, 32'd0);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic any_resp;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_data   = '0;
    req_amt    = '0;
    req_dir    = 1'b0;
    req_rot    = 1'b0;
    resp_ready = 1'b0;
    repeat (2) step();
    check_reset_outputs("reset");
    reset = 1'b0;
    step();

    // Left shift 1 << 5
    start_req(16'h0001, 4'd5, 1'b0, 1'b0);
    wait_resp("left5", 4, 16'h0020, 1'b1);
    finish_resp("left5", 16'h0020);

    // Max amount, left
    start_req(16'hFFFF, 4'd15, 1'b0, 1'b0);
    wait_resp("left15", 9, 16'h8000, 1'b1);
    finish_resp("left15", 16'h8000);

    // Right shift
    start_req(16'h8000, 4'd3, 1'b1, 1'b0);
    wait_resp("right3", 3, 16'h1000, 1'b1);
    finish_resp("right3", 16'h1000);

    // Zero amount never enters SHIFT
    start_req(16'hABCD, 4'd0, 1'b0, 1'b0);
    wait_resp("amt0", 1, 16'hABCD, 1'b0);
    finish_resp("amt0", 16'hABCD);

    // Single-bit right shift
    start_req(16'hF00F, 4'd1, 1'b1, 1'b0);
    wait_resp("right1", 2, 16'h7807, 1'b1);
    finish_resp("right1", 16'h7807);

    // resp_ready raised early: handshake on the first DONE edge
    resp_ready = 1'b1;
    start_req(16'h0001, 4'd1, 1'b0, 1'b0);
    wait_resp("early_ready", 2, 16'h0002, 1'b1);
    step();
    check("early_ready_idle", {30'd0, state}, 32'd0);
    resp_ready = 1'b0;
    step();

    // Backpressure: hold response, pulse a new request
    start_req(16'h1234, 4'd2, 1'b0, 1'b0);
    wait_resp("bp_first", 2, 16'h48D0, 1'b1);
    req_data  = 16'h0F0F;
    req_amt   = 4'd4;
    req_dir   = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_data", {16'd0, resp_data}, 32'h48D0);
      check("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("bp_release_idle", {30'd0, state}, 32'd0);
    check("bp_release_data", {16'd0, resp_data}, 32'h48D0);
    start_req(16'h0F0F, 4'd4, 1'b1, 1'b0);
    wait_resp("bp_second", 3, 16'h00F0, 1'b1);
    finish_resp("bp_second", 16'h00F0);

    // Mid-job asynchronous reset
    start_req(16'h0101, 4'd9, 1'b0, 1'b0);
    step();
    check("midrst_in_shift", {30'd0, state}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    step();
    reset = 1'b0;
    any_resp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (resp_valid) any_resp = 1'b1;
    end
    check("midrst_no_resp", {31'd0, any_resp}, 32'd0);
    start_req(16'h0003, 4'd2, 1'b0, 1'b0);
    wait_resp("after_rst", 2, 16'h000C, 1'b1);
    finish_resp("after_rst", 16'h000C);

`ifdef SHIFT_SEQUENCER_ROTATE_EN
    start_req(16'h8001, 4'd4, 1'b0, 1'b1);
    wait_resp("rot_left4", 3, 16'h0018, 1'b1);
    finish_resp("rot_left4", 16'h0018);
    start_req(16'h8001, 4'd4, 1'b1, 1'b1);
    wait_resp("rot_right4", 3, 16'h1800, 1'b1);
    finish_resp("rot_right4", 16'h1800);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
